// File: rtl/add_sub_pkg.sv
// Shared constants for the add/subtract datapath: operation select encoding.
package add_sub_pkg;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; chained by binary_add_sub_unit into a ripple-carry adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/binary_add_sub_unit.sv
// Registered WIDTH-bit two's-complement adder/subtractor with Carry and Overflow flags.
// Optional build macro ADD_SUB_SAT_EN: saturate Result to the signed limit on overflow.
module binary_add_sub_unit
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow
);
    logic        [WIDTH-1:0] bx;
    logic        [WIDTH:0]   c;
    logic        [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] result_d;
    logic                    carry_d;
    logic                    overflow_d;

    logic                    valid_q;
    logic signed [WIDTH-1:0] result_q;
    logic                    carry_q;
    logic                    overflow_q;

    // Overflow only happens when both adder operands share a sign, so A's sign tells the direction.
    function automatic logic signed [WIDTH-1:0] sat_limit(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign bx   = B ^ {WIDTH{mode}};
    assign c[0] = (mode == MODE_SUB);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a_i   (A[i]),
            .b_i   (bx[i]),
            .cin_i (c[i]),
            .sum_o (sum[i]),
            .cout_o(c[i+1])
        );
    end

    // Carry-in and carry-out of the sign bit differ exactly when the signed result leaves range.
    assign carry_d    = c[WIDTH];
    assign overflow_d = c[WIDTH] ^ c[WIDTH-1];

`ifdef ADD_SUB_SAT_EN
    assign result_d = overflow_d ? sat_limit(A[WIDTH-1]) : $signed(sum);
`else
    assign result_d = $signed(sum);
`endif

    // Output stage: data only loads on accepted operations, so idle inputs never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign Result    = result_q;
    assign Carry     = carry_q;
    assign Overflow  = overflow_q;
endmodule

// File: tb/tb_binary_add_sub_unit.sv
// Scoreboard bench for binary_add_sub_unit (WIDTH=4): integer reference model, queue-based checking.
module tb_binary_add_sub_unit;
    localparam int W = 4;

    typedef struct {
        logic         vld;
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         mode;
    logic         out_valid;
    logic [W-1:0] Result;
    logic         Carry;
    logic         Overflow;

    exp_t sbq[$];
    exp_t last;
    int   vectors    = 0;
    int   miscompares = 0;
    bit   stop       = 1'b0;

    binary_add_sub_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .mode     (mode),
        .out_valid(out_valid),
        .Result   (Result),
        .Carry    (Carry),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain signed/unsigned integer arithmetic on the operand values.
    function automatic exp_t model(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic m, input exp_t prev);
        exp_t e;
        int   sa, sb, ua, ub, r;
        e = prev;
        e.vld = v;
        if (!v) return e;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r  = m ? sa - sb : sa + sb;
        e.v   = (r > 7) || (r < -8);
        e.c   = m ? (ua >= ub) : (ua + ub > 15);
        e.res = r[W-1:0];
`ifdef ADD_SUB_SAT_EN
        if (e.v) e.res = (r > 0) ? 4'b0111 : 4'b1000;
`endif
        return e;
    endfunction

    // Apply one cycle of stimulus at the current negedge and queue its expected response.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t e;
        in_valid = v;
        A        = a;
        B        = b;
        mode     = m;
        e    = model(v, a, b, m, last);
        last = e;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_Result"},    int'(Result),    0);
        chk({tag, "_Carry"},     int'(Carry),     0);
        chk({tag, "_Overflow"},  int'(Overflow),  0);
    endtask

    // Valid op issued, then reset lands before its capturing edge: outputs clear at once, op is lost.
    task automatic mid_reset();
        in_valid = 1'b1;
        A        = W'($urandom);
        B        = W'($urandom);
        mode     = 1'($urandom);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        sbq.delete();
        last = '{vld: 1'b0, res: '0, c: 1'b0, v: 1'b0};
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    // Monitor: every non-reset cycle, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst || stop) continue;
            if (sbq.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("out_valid", int'(out_valid), int'(e.vld));
                chk("Result",    int'(Result),    int'(e.res));
                chk("Carry",     int'(Carry),     int'(e.c));
                chk("Overflow",  int'(Overflow),  int'(e.v));
            end
        end
    end

    initial begin
        last     = '{vld: 1'b0, res: '0, c: 1'b0, v: 1'b0};
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        mode     = 1'b0;
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 4'b0101, 4'b0011, 1'b0);
        drive(1'b1, 4'b0101, 4'b0011, 1'b1);
        drive(1'b1, 4'b1001, 4'b0111, 1'b0);
        drive(1'b1, 4'b1001, 4'b0111, 1'b1);
        idle(3);
        drive(1'b1, 4'b0000, 4'b1000, 1'b1);
        drive(1'b1, 4'b0111, 4'b1000, 1'b1);
        drive(1'b1, 4'b1000, 4'b1000, 1'b0);
        idle(1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int m = 0; m < 2; m++) begin
                    if ($urandom_range(0, 7) == 0) idle(1);
                    drive(1'b1, W'(a), W'(b), 1'(m));
                end

        mid_reset();
        idle(2);
        drive(1'b1, 4'b0110, 4'b0011, 1'b0);
        drive(1'b1, 4'b0110, 4'b0011, 1'b1);
        mid_reset();
        for (int k = 0; k < 60; k++)
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));

        stop = 1'b1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
